// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if: receiver FIFO handshake plus decoded key-event bus.
interface ps2_key_decoder_if;
    logic [7:0] ps2_data;
    logic       ps2_ready;
    logic       ps2_overflow;
    logic       nextdata_n;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       key_repeat;
    logic [7:0] key_ascii;
    logic [7:0] key_count;
    logic       key_held;
    logic       err;
    modport master (
        output ps2_data, ps2_ready, ps2_overflow,
        input  nextdata_n, key_valid, key_code, key_ext, key_release, key_repeat,
        input  key_ascii, key_count, key_held, err
    );
    modport slave (
        input  ps2_data, ps2_ready, ps2_overflow,
        output nextdata_n, key_valid, key_code, key_ext, key_release, key_repeat,
        output key_ascii, key_count, key_held, err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: set-2 scan code bytes to key events with prefix tracking,
// typematic suppression and ASCII lookup; pops the receiver FIFO itself.
module ps2_key_decoder (
    input logic             clk,
    input logic             clrn,
    ps2_key_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
    state_t     state_q;
    logic       ovf_q;
    logic       nextdata_n_q;
    logic       key_valid_q;
    logic [7:0] key_code_q;
    logic       key_ext_q;
    logic       key_release_q;
    logic       key_repeat_q;
    logic [7:0] key_ascii_q;
    logic [7:0] key_count_q;
    logic       key_held_q;
    logic       err_q;
    logic [7:0] held_code_q;
    logic       held_ext_q;
    logic [7:0] b;
    logic [7:0] ascii_d;
    logic       ovf_rise, fetch, in_ext, in_brk, match;
    assign b        = bus.ps2_data;
    assign ovf_rise = bus.ps2_overflow & ~ovf_q;
    assign fetch    = bus.ps2_ready & nextdata_n_q & ~ovf_rise;
    assign in_ext   = (state_q == EXT) || (state_q == EXT_BRK);
    assign in_brk   = (state_q == BRK) || (state_q == EXT_BRK);
    assign match    = key_held_q && (held_ext_q == in_ext) && (held_code_q == b);
    always_comb begin
        ascii_d = 8'h00;
        case (b)
            8'h1C: ascii_d = "a";  8'h32: ascii_d = "b";  8'h21: ascii_d = "c";
            8'h23: ascii_d = "d";  8'h24: ascii_d = "e";  8'h2B: ascii_d = "f";
            8'h34: ascii_d = "g";  8'h33: ascii_d = "h";  8'h43: ascii_d = "i";
            8'h3B: ascii_d = "j";  8'h42: ascii_d = "k";  8'h4B: ascii_d = "l";
            8'h3A: ascii_d = "m";  8'h31: ascii_d = "n";  8'h44: ascii_d = "o";
            8'h4D: ascii_d = "p";  8'h15: ascii_d = "q";  8'h2D: ascii_d = "r";
            8'h1B: ascii_d = "s";  8'h2C: ascii_d = "t";  8'h3C: ascii_d = "u";
            8'h2A: ascii_d = "v";  8'h1D: ascii_d = "w";  8'h22: ascii_d = "x";
            8'h35: ascii_d = "y";  8'h1A: ascii_d = "z";
            8'h45: ascii_d = "0";  8'h16: ascii_d = "1";  8'h1E: ascii_d = "2";
            8'h26: ascii_d = "3";  8'h25: ascii_d = "4";  8'h2E: ascii_d = "5";
            8'h36: ascii_d = "6";  8'h3D: ascii_d = "7";  8'h3E: ascii_d = "8";
            8'h46: ascii_d = "9";
            8'h29: ascii_d = 8'h20;
            8'h5A: ascii_d = 8'h0D;
            default: ascii_d = 8'h00;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_q       <= IDLE;
            ovf_q         <= 1'b0;
            nextdata_n_q  <= 1'b1;
            key_valid_q   <= 1'b0;
            key_code_q    <= 8'h00;
            key_ext_q     <= 1'b0;
            key_release_q <= 1'b0;
            key_repeat_q  <= 1'b0;
            key_ascii_q   <= 8'h00;
            key_count_q   <= 8'h00;
            key_held_q    <= 1'b0;
            err_q         <= 1'b0;
            held_code_q   <= 8'h00;
            held_ext_q    <= 1'b0;
        end else begin
            ovf_q        <= bus.ps2_overflow;
            key_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            nextdata_n_q <= 1'b1;
            if (ovf_rise) begin
                state_q <= IDLE;
                err_q   <= 1'b1;
            end else if (fetch) begin
                nextdata_n_q <= 1'b0;
                if (b == 8'hE0) begin
                    err_q   <= state_q != IDLE;
                    state_q <= EXT;
                end else if (b == 8'hF0) begin
                    err_q   <= in_brk;
                    state_q <= in_brk ? state_q : (in_ext ? EXT_BRK : BRK);
                end else if (b == 8'h00 || b == 8'hFF) begin
                    err_q   <= 1'b1;
                    state_q <= IDLE;
                end else begin
                    key_valid_q   <= 1'b1;
                    key_code_q    <= b;
                    key_ext_q     <= in_ext;
                    key_release_q <= in_brk;
                    key_ascii_q   <= in_ext ? 8'h00 : ascii_d;
                    key_repeat_q  <= !in_brk && match;
                    state_q       <= IDLE;
                    if (in_brk) begin
                        if (match) key_held_q <= 1'b0;
                    end else if (!match) begin
                        key_count_q <= key_count_q + 8'd1;
                        held_code_q <= b;
                        held_ext_q  <= in_ext;
                        key_held_q  <= 1'b1;
                    end
                end
            end
        end
    end
    assign bus.nextdata_n  = nextdata_n_q;
    assign bus.key_valid   = key_valid_q;
    assign bus.key_code    = key_code_q;
    assign bus.key_ext     = key_ext_q;
    assign bus.key_release = key_release_q;
    assign bus.key_repeat  = key_repeat_q;
    assign bus.key_ascii   = key_ascii_q;
    assign bus.key_count   = key_count_q;
    assign bus.key_held    = key_held_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: FIFO-fed directed and random byte streams checked each
// cycle against a prefix-flag reference model of the decoder.
module tb_ps2_key_decoder;
    logic clk = 1'b0;
    logic clrn = 1'b0;
    int total = 0;
    int bad = 0;
    logic [7:0] fifo[$];
    ps2_key_decoder_if bus ();
    ps2_key_decoder dut (.clk(clk), .clrn(clrn), .bus(bus));
    always #5 clk = ~clk;
    logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] pool [10] = '{8'h1C, 8'h32, 8'h29, 8'h5A, 8'h45, 8'h16, 8'h75, 8'h6B, 8'h1A, 8'h0D};
    logic       m_valid, m_err, m_ndn, m_ext, m_rel, m_rep, m_held, m_hext, pext, pbrk, m_ovf_prev;
    logic [7:0] m_code, m_ascii, m_count, m_hcode;
    initial m_ovf_prev = 1'b0;
    function automatic logic [7:0] ascii_of(input logic [7:0] c);
        for (int i = 0; i < 26; i++) if (letters[i] == c) return 8'h61 + 8'(i);
        for (int i = 0; i < 10; i++) if (digits[i] == c) return 8'h30 + 8'(i);
        if (c == 8'h29) return 8'h20;
        if (c == 8'h5A) return 8'h0D;
        return 8'h00;
    endfunction
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        {m_valid, m_err, m_ext, m_rel, m_rep, m_held, m_hext, pext, pbrk, m_ovf_prev} = '0;
        {m_code, m_ascii, m_count, m_hcode} = '0;
        m_ndn = 1'b1;
    endtask
    task automatic consume(input logic [7:0] b);
        logic same;
        if (b == 8'hE0) begin
            m_err = pext || pbrk;
            pext = 1'b1;
            pbrk = 1'b0;
        end else if (b == 8'hF0) begin
            if (pbrk) m_err = 1'b1;
            pbrk = 1'b1;
        end else if (b == 8'h00 || b == 8'hFF) begin
            m_err = 1'b1;
            pext = 1'b0;
            pbrk = 1'b0;
        end else begin
            same = m_held && m_hext == pext && m_hcode == b;
            m_valid = 1'b1;
            m_code = b;
            m_ext = pext;
            m_rel = pbrk;
            m_ascii = pext ? 8'h00 : ascii_of(b);
            if (pbrk) begin
                m_rep = 1'b0;
                if (same) m_held = 1'b0;
            end else begin
                m_rep = same;
                if (!same) begin
                    m_count = m_count + 8'd1;
                    m_hcode = b;
                    m_hext = pext;
                    m_held = 1'b1;
                end
            end
            pext = 1'b0;
            pbrk = 1'b0;
        end
    endtask
    task automatic present();
        bus.ps2_ready = fifo.size() != 0;
        bus.ps2_data = fifo.size() != 0 ? fifo[0] : 8'h00;
    endtask
    task automatic push(input logic [7:0] b);
        fifo.push_back(b);
        present();
    endtask
    task automatic tick();
        logic pop, rdy, ndn, rst, rise;
        logic [7:0] dat;
        pop = !bus.nextdata_n;
        rdy = bus.ps2_ready;
        ndn = bus.nextdata_n;
        dat = bus.ps2_data;
        rst = !clrn;
        rise = bus.ps2_overflow && !m_ovf_prev;
        @(posedge clk);
        if (rst) model_reset();
        else begin
            m_ovf_prev = bus.ps2_overflow;
            m_valid = 1'b0;
            m_err = 1'b0;
            m_ndn = 1'b1;
            if (rise) begin
                m_err = 1'b1;
                pext = 1'b0;
                pbrk = 1'b0;
            end else if (rdy && ndn) begin
                m_ndn = 1'b0;
                consume(dat);
            end
        end
        #1;
        if (pop && fifo.size() != 0) void'(fifo.pop_front());
        present();
        chk("nextdata_n", 8'(bus.nextdata_n), 8'(m_ndn));
        chk("key_valid", 8'(bus.key_valid), 8'(m_valid));
        chk("err", 8'(bus.err), 8'(m_err));
        chk("key_code", bus.key_code, m_code);
        chk("key_ext", 8'(bus.key_ext), 8'(m_ext));
        chk("key_release", 8'(bus.key_release), 8'(m_rel));
        chk("key_repeat", 8'(bus.key_repeat), 8'(m_rep));
        chk("key_ascii", bus.key_ascii, m_ascii);
        chk("key_count", bus.key_count, m_count);
        chk("key_held", 8'(bus.key_held), 8'(m_held));
    endtask
    task automatic drain();
        for (int i = 0; i < 100 && (fifo.size() != 0 || !bus.nextdata_n); i++) tick();
        chk("drain", 8'(fifo.size()), 8'h00);
    endtask
    task automatic do_reset();
        clrn = 1'b0;
        tick();
        tick();
        clrn = 1'b1;
    endtask
    initial begin
        bus.ps2_overflow = 1'b0;
        present();
        model_reset();
        do_reset();
        chk("reset_ndn", 8'(bus.nextdata_n), 8'h01);
        chk("reset_count", bus.key_count, 8'h00);
        push(8'h1C);
        drain();
        chk("first_code", bus.key_code, 8'h1C);
        chk("first_ascii", bus.key_ascii, 8'h61);
        chk("first_count", bus.key_count, 8'h01);
        chk("first_held", 8'(bus.key_held), 8'h01);
        // extended make then extended release
        push(8'hE0); push(8'h75); drain();
        push(8'hE0); push(8'hF0); push(8'h75); drain();
        chk("ext_rel_ext", 8'(bus.key_ext), 8'h01);
        chk("ext_rel_rel", 8'(bus.key_release), 8'h01);
        chk("ext_rel_held", 8'(bus.key_held), 8'h00);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push(8'h1C);
            drain();
            chk("rep_flag", 8'(bus.key_repeat), i == 0 ? 8'h00 : 8'h01);
            chk("rep_count", bus.key_count, 8'h01);
        end
        push(8'hF0); push(8'h1C); push(8'h1C); drain();
        chk("remake_count", bus.key_count, 8'h02);
        // 256 distinct make/break pairs wrap the counter back to its start
        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic e;
            logic [7:0] c;
            e = i >= 127;
            c = e ? 8'(i - 126) : 8'(i + 1);
            if (e) push(8'hE0);
            push(c);
            drain();
            if (e) push(8'hE0);
            push(8'hF0); push(c); drain();
        end
        chk("wrap_count", bus.key_count, 8'h00);
        push(8'hF0); push(8'hF0); push(8'h1C); drain();
        chk("ff_rel", 8'(bus.key_release), 8'h01);
        push(8'hE0); push(8'hFF); push(8'h29); drain();
        chk("ff_ext", 8'(bus.key_ext), 8'h00);
        push(8'hE0); drain();
        bus.ps2_overflow = 1'b1;
        tick();
        chk("ovf_err", 8'(bus.err), 8'h01);
        push(8'h29); drain();
        chk("ovf_ascii", bus.key_ascii, 8'h20);
        chk("ovf_ext", 8'(bus.key_ext), 8'h00);
        bus.ps2_overflow = 1'b0;
        tick();
        push(8'hF0); drain();
        clrn = 1'b0;
        tick();
        chk("midrst_ndn", 8'(bus.nextdata_n), 8'h01);
        chk("midrst_count", bus.key_count, 8'h00);
        clrn = 1'b1;
        push(8'h1C); drain();
        chk("midrst_rel", 8'(bus.key_release), 8'h00);
        for (int n = 0; n < 3000; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (fifo.size() < 8) begin
                if (r < 10) push(8'hE0);
                else if (r < 22) push(8'hF0);
                else if (r < 25) push(r[0] ? 8'hFF : 8'h00);
                else if (r < 35) push(8'($urandom_range(1, 254)));
                else push(pool[$urandom_range(0, 9)]);
            end
            if ($urandom_range(0, 29) == 0) bus.ps2_overflow = ~bus.ps2_overflow;
            clrn = $urandom_range(0, 299) != 0;
            repeat ($urandom_range(0, 3)) tick();
        end
        clrn = 1'b1;
        bus.ps2_overflow = 1'b0;
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Consumes the byte stream of the PS/2 keyboard receiver (`ps2_keyboard`: `data`, `ready`, `nextdata_n`, `overflow`) and turns raw set-2 scan codes into key events. It tracks make/break (0xF0) and extended (0xE0) prefixes, suppresses typematic repeats from the press count, and converts plain codes to ASCII. It sits directly downstream of the receiver, in its place in the top-level wrapper, and drives the receiver's FIFO pop strobe.

## Interface
- No parameters.
- `clk` input 1: system clock; all state updates on the rising edge.
- `clrn` input 1: synchronous active-low reset, sampled on the rising edge of `clk`.
- `ps2_data` input 8: head byte of the receiver FIFO.
- `ps2_ready` input 1: FIFO non-empty; `ps2_data` is valid while high.
- `ps2_overflow` input 1: receiver FIFO overflow flag.
- `nextdata_n` output 1: active-low pop strobe to the receiver; registered.
- `key_valid` output 1: one-cycle pulse, key event present.
- `key_code` output 8: scan code of the event, without prefixes.
- `key_ext` output 1: the event carried the 0xE0 prefix.
- `key_release` output 1: the event is a break (1) or a make (0).
- `key_repeat` output 1: the event is a make of the key already held (typematic).
- `key_ascii` output 8: ASCII for the event code; 0x00 if none.
- `key_count` output 8: count of new (non-repeat) make events; wraps.
- `key_held` output 1: a key is currently down.
- `err` output 1: one-cycle pulse on a protocol error or an overflow.

## Operation
- All outputs are registered.
- Reset values: `nextdata_n`=1; all other outputs 0. Reset also sets FSM=IDLE, the held code/ext register=0, and the overflow edge register=0.
- Fetch: a byte is consumed at a clock edge where `ps2_ready`=1, `nextdata_n`=1, and the overflow-resync rule below does not apply.
  - At that edge `nextdata_n`<=0 for exactly one cycle. The receiver pops at the following edge.
  - While `nextdata_n`=0 the decoder never samples. Maximum rate is 1 byte per 2 cycles.
- FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0).
  - 0xE0: IDLE->EXT. In EXT, BRK or EXT_BRK it pulses `err` and goes to EXT.
  - 0xF0: IDLE->BRK, EXT->EXT_BRK. In BRK or EXT_BRK it pulses `err`, state unchanged.
  - 0x00 or 0xFF (keyboard error codes): any state -> IDLE, `err` pulse, no event.
  - Any other byte B produces an event, then FSM->IDLE:
    - `key_code`=B.
    - `key_ext`=1 in EXT or EXT_BRK, else 0.
    - `key_release`=1 in BRK or EXT_BRK, else 0.
- Make handling:
  - If `key_held`=1 and {ext,B} equals the held {ext,code}: `key_repeat`=1 and `key_count` is unchanged.
  - Otherwise: `key_repeat`=0, `key_count`+1 (mod 256), held register<={ext,B}, `key_held`<=1.
- Break handling:
  - `key_repeat`=0.
  - If {ext,B} equals the held pair, `key_held`<=0. A break for any other key leaves the held state untouched.
- ASCII table (applies only when ext=0, for both make and break):
  - Set-2 letters give lowercase: 0x1C 'a' 0x61, 0x32 'b', 0x21 'c', ... 0x1A 'z'.
  - Digits: 0x45 '0' 0x30, 0x16 '1', 0x1E '2', ... 0x46 '9'.
  - 0x29 gives 0x20; 0x5A gives 0x0D.
  - Any other code, and any ext=1 code, gives 0x00.
- Overflow:
  - A rising edge of `ps2_overflow` (registered compare) forces FSM->IDLE and pulses `err`.
  - No byte is fetched on that edge; the held state is kept.
- `key_code`, `key_ext`, `key_release`, `key_repeat` and `key_ascii` hold their values until the next event.

## Timing
- Byte valid in cycle N (`ps2_ready`=1, `nextdata_n`=1): `key_valid`/`err` and `nextdata_n`=0 in cycle N+1. The next sample is possible at the end of cycle N+2.
- A prefix byte produces no `key_valid`. The event for E0 F0 xx appears 1 cycle after xx is fetched.
- `key_count` and `key_held` update in the same cycle that `key_valid` is high.
- `key_count` wraps 0xFF->0x00 with no flag.
- Reset mid-sequence: pending prefixes are dropped. If `nextdata_n` was 0 in the reset cycle, the receiver's pop still happens at that edge, so the byte is lost. This is acceptable.
- Overflow edge and a fetchable byte at the same edge: the overflow wins and the byte stays in the FIFO.

## Test plan
- Reset, then FIFO 0x1C -> one `key_valid`, `key_code`=0x1C, `key_release`=0, `key_ascii`=0x61, `key_count`=1, `key_held`=1, `nextdata_n` low exactly 1 cycle.
- 0xE0 0xF0 0x75 after a make of E0 75 -> a single release event with `key_ext`=1, `key_ascii`=0x00, `key_held`=0; no event for the prefixes.
- Make 0x1C ×3 -> `key_repeat`=0,1,1; `key_count`=1,1,1. Then F0 1C followed by 1C -> `key_count`=2.
- 256 distinct make/break pairs -> `key_count` wraps to 0x00.
- Bytes F0 F0 1C -> `err` pulse on the second F0, then a release of 0x1C. Byte 0xFF in EXT -> `err`, FSM back to IDLE, no event.
- Raise `ps2_overflow` after E0 -> `err` pulse; the next byte 0x29 gives a make with `key_ext`=0, `key_ascii`=0x20.
- Assert `clrn`=0 after F0 -> all outputs 0, `nextdata_n`=1; the following 0x1C is decoded as a make.
